// File: rtl/ascii_sum_ctrl_if.sv
// Character-stream handshake bundle between the ASCII front end, the adder
// sequencer and the output/display path.
interface ascii_sum_ctrl_if;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    modport master (
        output in_char, in_valid, out_ready,
        input  in_ready, out_char, out_valid, busy
    );

    modport slave (
        input  in_char, in_valid, out_ready,
        output in_ready, out_char, out_valid, busy
    );
endinterface

// File: rtl/ascii_sum_ctrl.sv
// Serial ASCII decimal adder sequencer: parses "A+B=", adds LSD first through one
// shared BCD slice and streams the NDIG+1 digit sum (or a single '?') back out.
module ascii_sum_ctrl #(
    parameter int NDIG = 4
) (
    input  logic            clk,
    input  logic            rst,
    ascii_sum_ctrl_if.slave bus
);
    localparam int CW = $clog2(NDIG + 2);
    localparam int IW = $clog2(NDIG + 1);
    localparam int DW = 4 * NDIG;

    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_EQ   = 8'h3D;
    localparam logic [7:0] CH_QM   = 8'h3F;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        ADD     = 3'd2,
        EMIT    = 3'd3,
        DRAIN   = 3'd4,
        ERR_OUT = 3'd5
    } state_t;

    // One-digit BCD add slice, result is {carry_out, digit}.
    function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b,
                                           input logic c);
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        t = s - 5'd10;
        if (s > 5'd9) begin
            bcd_add = {1'b1, t[3:0]};
        end else begin
            bcd_add = s;
        end
    endfunction

    state_t         state_r;
    logic [DW-1:0]  a_r;
    logic [DW-1:0]  b_r;
    logic [DW-1:0]  r_r;
    logic [CW-1:0]  cnt_a_r;
    logic [CW-1:0]  cnt_b_r;
    logic [IW-1:0]  idx_r;
    logic           carry_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [7:0]     out_char_r;
    logic           busy_r;

    logic           in_fire_s;
    logic           out_fire_s;
    logic           is_digit_s;
    logic           is_plus_s;
    logic           is_eq_s;
    logic [4:0]     slice_s;

    // Handshake qualifiers, character classification and the shared add slice.
    always_comb begin
        in_fire_s  = bus.in_valid && in_ready_r;
        out_fire_s = out_valid_r && bus.out_ready;
        is_digit_s = (bus.in_char >= CH_0) && (bus.in_char <= CH_9);
        is_plus_s  = (bus.in_char == CH_PLUS);
        is_eq_s    = (bus.in_char == CH_EQ);
        slice_s    = bcd_add(a_r[3:0], b_r[3:0], carry_r);
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_char  = out_char_r;
    assign bus.busy      = busy_r;

    // Sequencer: parse, serial add (operands shift right, result shifts in at the top), emit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= GET_A;
            a_r         <= {DW{1'b0}};
            b_r         <= {DW{1'b0}};
            r_r         <= {DW{1'b0}};
            cnt_a_r     <= {CW{1'b0}};
            cnt_b_r     <= {CW{1'b0}};
            idx_r       <= {IW{1'b0}};
            carry_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_char_r  <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                GET_A: begin
                    if (in_fire_s) begin
                        if (is_digit_s) begin
                            if (cnt_a_r < CW'(NDIG)) begin
                                a_r     <= {a_r[DW-5:0], bus.in_char[3:0]};
                                cnt_a_r <= cnt_a_r + CW'(1);
                            end else begin
                                cnt_a_r <= CW'(NDIG + 1);
                                state_r <= DRAIN;
                            end
                        end else if (is_plus_s && (cnt_a_r != {CW{1'b0}})) begin
                            state_r <= GET_B;
                        end else if (is_eq_s) begin
                            state_r     <= ERR_OUT;
                            in_ready_r  <= 1'b0;
                            busy_r      <= 1'b1;
                            out_valid_r <= 1'b1;
                            out_char_r  <= CH_QM;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end
                end
                GET_B: begin
                    if (in_fire_s) begin
                        if (is_digit_s) begin
                            if (cnt_b_r < CW'(NDIG)) begin
                                b_r     <= {b_r[DW-5:0], bus.in_char[3:0]};
                                cnt_b_r <= cnt_b_r + CW'(1);
                            end else begin
                                cnt_b_r <= CW'(NDIG + 1);
                                state_r <= DRAIN;
                            end
                        end else if (is_eq_s && (cnt_b_r != {CW{1'b0}})) begin
                            state_r    <= ADD;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                            idx_r      <= {IW{1'b0}};
                            carry_r    <= 1'b0;
                        end else if (is_eq_s) begin
                            state_r     <= ERR_OUT;
                            in_ready_r  <= 1'b0;
                            busy_r      <= 1'b1;
                            out_valid_r <= 1'b1;
                            out_char_r  <= CH_QM;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end
                end
                ADD: begin
                    a_r     <= {4'h0, a_r[DW-1:4]};
                    b_r     <= {4'h0, b_r[DW-1:4]};
                    r_r     <= {slice_s[3:0], r_r[DW-1:4]};
                    carry_r <= slice_s[4];
                    if (idx_r == IW'(NDIG - 1)) begin
                        // Final carry is the MSB character, presented straight away.
                        state_r     <= EMIT;
                        idx_r       <= IW'(NDIG);
                        out_valid_r <= 1'b1;
                        out_char_r  <= {4'h3, 3'b000, slice_s[4]};
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                EMIT: begin
                    if (out_fire_s) begin
                        if (idx_r == {IW{1'b0}}) begin
                            state_r     <= GET_A;
                            a_r         <= {DW{1'b0}};
                            b_r         <= {DW{1'b0}};
                            r_r         <= {DW{1'b0}};
                            cnt_a_r     <= {CW{1'b0}};
                            cnt_b_r     <= {CW{1'b0}};
                            carry_r     <= 1'b0;
                            in_ready_r  <= 1'b1;
                            out_valid_r <= 1'b0;
                            busy_r      <= 1'b0;
                        end else begin
                            out_char_r <= {4'h3, r_r[DW-1 -: 4]};
                            r_r        <= {r_r[DW-5:0], 4'h0};
                            idx_r      <= idx_r - IW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (in_fire_s && is_eq_s) begin
                        state_r     <= ERR_OUT;
                        in_ready_r  <= 1'b0;
                        busy_r      <= 1'b1;
                        out_valid_r <= 1'b1;
                        out_char_r  <= CH_QM;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                ERR_OUT: begin
                    if (out_fire_s) begin
                        state_r     <= GET_A;
                        a_r         <= {DW{1'b0}};
                        b_r         <= {DW{1'b0}};
                        r_r         <= {DW{1'b0}};
                        cnt_a_r     <= {CW{1'b0}};
                        cnt_b_r     <= {CW{1'b0}};
                        carry_r     <= 1'b0;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= GET_A;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ascii_sum_ctrl.sv
// Randomized bench for ascii_sum_ctrl: each request string is checked against a
// string-level model (split at '=', validate "digits+digits", add as integers).
module tb_ascii_sum_ctrl;
    localparam int NDIG = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ascii_sum_ctrl_if io();

    ascii_sum_ctrl #(.NDIG(NDIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (io)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rdy_mode = 0;
    int   rdy_phase = 0;
    int   acc_edge = 0;
    int   first_valid = -1;
    int   last_hs = -1;
    byte  got[$];
    logic prev_stall = 1'b0;
    logic [7:0] prev_char = 8'h00;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference: everything before the first '=' must be 1..NDIG digits, '+', 1..NDIG digits.
    function automatic string model(input string s);
        int     plus_pos = -1;
        int     len = 0;
        bit     ok = 1'b1;
        longint va = 0;
        longint vb = 0;
        longint sum;
        string  r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h3D) break;
            len++;
            if (s[i] == 8'h2B) begin
                if (plus_pos < 0) plus_pos = i;
                else ok = 1'b0;
            end else if (s[i] >= 8'h30 && s[i] <= 8'h39) begin
                if (plus_pos < 0) va = va * 10 + longint'(s[i] - 8'h30);
                else              vb = vb * 10 + longint'(s[i] - 8'h30);
            end else begin
                ok = 1'b0;
            end
        end
        if (plus_pos < 1 || plus_pos > NDIG) ok = 1'b0;
        if ((len - plus_pos - 1) < 1 || (len - plus_pos - 1) > NDIG) ok = 1'b0;
        if (!ok) return "?";
        sum = va + vb;
        for (int k = 0; k <= NDIG; k++) begin
            r = {$sformatf("%0d", sum % 10), r};
            sum = sum / 10;
        end
        return r;
    endfunction

    function automatic string rand_str();
        string s = "";
        string pool = "0123456789+/:a ";
        int    kind = int'($urandom_range(0, 9));
        if (kind < 7) begin
            int na = int'($urandom_range(1, (kind == 6) ? NDIG + 1 : NDIG));
            int nb = int'($urandom_range(1, NDIG));
            bit nines = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < na; i++) s = {s, $sformatf("%0d", nines ? 9 : int'($urandom_range(0, 9)))};
            s = {s, "+"};
            for (int i = 0; i < nb; i++) s = {s, $sformatf("%0d", nines ? 9 : int'($urandom_range(0, 9)))};
        end else begin
            int n = int'($urandom_range(0, 6));
            for (int i = 0; i < n; i++) s = {s, $sformatf("%c", pool[int'($urandom_range(0, pool.len() - 1))])};
        end
        return {s, "="};
    endfunction

    // Cycle counter: value equals the number of rising edges so far.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: collects handshaken chars and checks stall stability and input blocking.
    initial forever begin
        @(negedge clk);
        if (prev_stall) begin
            check_val("stall_valid_held", int'(io.out_valid), 1);
            check_val("stall_char_held", int'(io.out_char), int'(prev_char));
        end
        if (io.busy) check_val("busy_blocks_input", int'(io.in_ready), 0);
        if (!rst && io.out_valid && first_valid < 0) first_valid = cyc;
        if (!rst && io.out_valid && io.out_ready) begin
            got.push_back(io.out_char);
            last_hs = cyc + 1;
        end
        prev_stall = !rst && io.out_valid && !io.out_ready;
        prev_char  = io.out_char;
    end

    // out_ready driver: 0 tied high, 1 random, 2 the 0,0,0,1 per-char pattern.
    initial begin
        io.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: io.out_ready = 1'b1;
                1: io.out_ready = ($urandom_range(0, 1) == 1);
                default: begin
                    if (io.out_valid) begin
                        io.out_ready = (rdy_phase == 3);
                        rdy_phase = (rdy_phase == 3) ? 0 : rdy_phase + 1;
                    end else begin
                        io.out_ready = 1'b0;
                        rdy_phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic send_char(input byte c, inout int waits);
        int guard = 0;
        io.in_char  = c;
        io.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (io.in_ready) break;
            waits++;
            guard++;
            if (guard > 50) begin
                check_val("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #2;
        acc_edge = cyc;
    endtask

    task automatic run_txn(input string s, input bit chk_timing);
        string exp_s = model(s);
        int    waits = 0;
        int    guard = 0;
        got.delete();
        first_valid = -1;
        last_hs = -1;
        for (int i = 0; i < s.len(); i++) send_char(s[i], waits);
        check_val({"in_ready_held ", s}, waits, 0);
        // Keep a junk char offered while busy; it must not be taken.
        io.in_char = 8'h35;
        while (got.size() < exp_s.len() && guard < 200) begin
            @(posedge clk);
            #2;
            guard++;
        end
        io.in_valid = 1'b0;
        check_val({"result_in_time ", s}, int'(guard < 200), 1);
        @(negedge clk);
        check_val({"in_ready_after ", s}, int'(io.in_ready), 1);
        check_val({"busy_after ", s}, int'(io.busy), 0);
        repeat (2) @(negedge clk);
        check_val({"char_count ", s}, got.size(), exp_s.len());
        for (int k = 0; k < exp_s.len() && k < got.size(); k++)
            check_val($sformatf("char[%0d] %s", k, s), int'(got[k]), int'(exp_s[k]));
        if (chk_timing) begin
            check_val({"first_valid_cycles ", s}, first_valid - acc_edge + 1, (exp_s == "?") ? 1 : NDIG + 1);
            check_val({"last_handshake_edge ", s}, last_hs - acc_edge, (exp_s == "?") ? 1 : 2 * NDIG + 1);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int waits = 0;
        int guard = 0;
        string rs;
        io.in_char  = 8'h00;
        io.in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_val("reset_in_ready", int'(io.in_ready), 1);
        check_val("reset_out_valid", int'(io.out_valid), 0);
        check_val("reset_out_char", int'(io.out_char), 0);
        check_val("reset_busy", int'(io.busy), 0);
        @(posedge clk);
        #2;

        rdy_mode = 0;
        run_txn("12+34=", 1'b1);
        run_txn("9999+9999=", 1'b1);
        run_txn("12345+1=", 1'b1);
        run_txn("5+5=", 1'b1);
        run_txn("+3=", 1'b1);
        run_txn("7+=", 1'b1);
        run_txn("7a+1=", 1'b1);
        run_txn("7=", 1'b1);
        run_txn("1+12345=", 1'b1);

        rdy_mode = 2;
        run_txn("0+0=", 1'b0);
        rdy_mode = 0;

        // Reset during EMIT, right after the second result char is taken.
        got.delete();
        rs = "12+34=";
        for (int i = 0; i < rs.len(); i++) send_char(rs[i], waits);
        io.in_valid = 1'b0;
        while (got.size() < 2 && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check_val("midreset_reach_emit", int'(guard < 100), 1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_val("midreset_out_valid", int'(io.out_valid), 0);
        check_val("midreset_in_ready", int'(io.in_ready), 1);
        check_val("midreset_busy", int'(io.busy), 0);
        check_val("midreset_char_count", got.size(), 2);
        @(posedge clk);
        #2;
        run_txn("1+1=", 1'b1);

        for (int n = 0; n < 40; n++) begin
            rdy_mode = ($urandom_range(0, 2) == 0) ? 0 : 1;
            run_txn(rand_str(), rdy_mode == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
